// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter:
// state encoding, sizing constants and the rotating priority scan.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  // Result of a round-robin scan: whether anyone was found, and who
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requester found scanning start, start+1, ... (mod NUM_REQ).
  // The loop runs from the farthest offset down so the nearest hit wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   start);
    pick_t            res;
    logic [SEL_W-1:0] k;
    res.found = 1'b0;
    res.idx   = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = start + SEL_W'(i);
      if (req[k]) begin
        res.found = 1'b1;
        res.idx   = k;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mux4_sel.sv
// Combinational 4:1 single-bit mux shared by all requesters.
module mux4_sel
  import mux_arb_pkg::*;
(
  input  logic [SEL_W-1:0]   sel,
  input  logic [NUM_REQ-1:0] din,
  output logic               dout
);

  // Pick the data bit of the selected source
  always_comb begin
    dout = din[sel];
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 bit mux. Grant and select
// are registered so sel only moves on a clock edge; the selected bit is
// registered with a valid flag one cycle later.
// Optional feature: define ARB_BURST_LIMIT_EN to cap each ownership at
// MAX_BURST consecutive cycles; without it the owner keeps the mux until
// it drops its request.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] din,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               dout,
  output logic               dout_valid
);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic               dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               mux_bit;
  logic               expire;
  logic               keep;
  pick_t              pick;

`ifdef ARB_BURST_LIMIT_EN
  localparam int CNT_W = $clog2(MAX_BURST);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_max_burst;
  assign unused_max_burst = (MAX_BURST > 0);
`endif

  mux4_sel u_mux4_sel (
    .sel  (sel_q),
    .din  (din),
    .dout (mux_bit)
  );

  // Next-state logic: arbitrate from IDLE, hold or hand off in GRANT
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    expire  = 1'b0;
    keep    = 1'b0;
    pick    = '0;
`ifdef ARB_BURST_LIMIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        pick = rr_pick(req, ptr_q);
      end
      ARB_GRANT: begin
`ifdef ARB_BURST_LIMIT_EN
        expire = req[sel_q] && (cnt_q == CNT_W'(MAX_BURST - 1));
`endif
        keep = req[sel_q] && !expire;
        // A released owner has req low so the scan skips it naturally;
        // an expired owner sits last in the scan and wins only if alone
        if (!keep) begin
          pick = rr_pick(req, sel_q + 2'd1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
      end
    endcase

    if (keep) begin
`ifdef ARB_BURST_LIMIT_EN
      cnt_d = cnt_q + CNT_W'(1);
`endif
    end else if (pick.found) begin
      state_d = ARB_GRANT;
      gnt_d   = NUM_REQ'(1) << pick.idx;
      sel_d   = pick.idx;
      ptr_d   = pick.idx + 2'd1;
`ifdef ARB_BURST_LIMIT_EN
      cnt_d   = '0;
`endif
    end else begin
      state_d = ARB_IDLE;
      gnt_d   = '0;
    end
  end

  // Datapath: capture the granted bit, otherwise keep the last sample
  always_comb begin
    dout_valid_d = |gnt_q;
    dout_d       = (|gnt_q) ? mux_bit : dout_q;
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      gnt_q        <= '0;
      sel_q        <= '0;
      ptr_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      sel_q        <= sel_d;
      ptr_q        <= ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
`ifdef ARB_BURST_LIMIT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign gnt        = gnt_q;
  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against an ownership-level model.
module tb_mux4_rr_arbiter;

  localparam int MAX_BURST = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       dout;
  logic       dout_valid;

  int compare_count = 0;
  int error_count   = 0;

  // Reference model: who owns the mux, how long it has held it, where
  // the next idle scan begins, and the expected datapath registers
  int         m_owner;
  int         m_held;
  int         m_next;
  logic [1:0] m_sel;
  logic       m_dout;
  logic       m_valid;

  mux4_rr_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .din        (din),
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkVal(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compare_count++;
    assert (obs === exp) else begin
      error_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_owner = -1;
    m_held  = 0;
    m_next  = 0;
    m_sel   = 2'd0;
    m_dout  = 1'b0;
    m_valid = 1'b0;
  endtask

  // One rising edge of the model using the inputs present at that edge
  task automatic modelStep(input logic [3:0] r, input logic [3:0] d);
    int  start;
    int  winner;
    bit  keep;
    if (m_owner >= 0) begin
      m_dout  = d[m_owner];
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    keep  = 1'b0;
    start = m_next;
    if (m_owner >= 0) begin
      keep  = r[m_owner] && !(BURST_ON && m_held >= MAX_BURST);
      start = (m_owner + 1) % 4;
    end
    if (keep) begin
      m_held++;
    end else begin
      winner = -1;
      for (int j = 0; j < 4; j++) begin
        if (winner < 0 && r[(start + j) % 4]) winner = (start + j) % 4;
      end
      m_owner = winner;
      if (winner >= 0) begin
        m_sel  = 2'(winner);
        m_next = (winner + 1) % 4;
        m_held = 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] exp_gnt;
    exp_gnt = 4'b0000;
    if (m_owner >= 0) exp_gnt[m_owner] = 1'b1;
    checkVal({tag, ".gnt"}, gnt, exp_gnt);
    checkVal({tag, ".sel"}, {2'b00, sel}, {2'b00, m_sel});
    checkVal({tag, ".valid"}, {3'b000, dout_valid}, {3'b000, m_valid});
    checkVal({tag, ".dout"}, {3'b000, dout}, {3'b000, m_dout});
    checkVal({tag, ".onehot"}, {3'b000, $onehot0(gnt)}, 4'b0001);
  endtask

  // Drive inputs, take one clock edge, then compare just after the edge
  task automatic applyStimulus(input string tag, input logic [3:0] r, input logic [3:0] d);
    req = r;
    din = d;
    @(posedge clk);
    modelStep(r, d);
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset between edges, held across one edge, released mid-cycle
  task automatic doReset(input string tag);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput({tag, ".async"});
    @(posedge clk);
    #1;
    checkOutput({tag, ".hold"});
    #2;
    rst_n = 1'b1;
  endtask

  logic [3:0] rot_req [9] = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
                              4'b1111, 4'b1011, 4'b1111, 4'b0111};
  logic [3:0] rot_gnt [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                              4'b0100, 4'b1000, 4'b1000, 4'b0001};

  initial begin
    logic [3:0] r;
    logic [3:0] exp_g;
    rst_n = 1'b1;
    req   = 4'b0100;
    din   = 4'b0100;
    modelReset();
    #1;

    // Reset with a single requester waiting, then grant and data latency
    doReset("reset");
    applyStimulus("single.c1", 4'b0100, 4'b0100);
    checkVal("single.gnt", gnt, 4'b0100);
    checkVal("single.sel", {2'b00, sel}, 4'd2);
    applyStimulus("single.c2", 4'b0100, 4'b0100);
    checkVal("single.dout", {3'b000, dout}, 4'b0001);
    checkVal("single.dvalid", {3'b000, dout_valid}, 4'b0001);

    // Round-robin rotation with one-cycle drops and no gaps
    doReset("rot.rst");
    for (int i = 0; i < 9; i++) begin
      applyStimulus("rot", rot_req[i], 4'(i));
      checkVal($sformatf("rot.gnt%0d", i), gnt, rot_gnt[i]);
    end

    // Owner 2 releases as 1 and 3 arrive: scan from 3 picks 3
    doReset("late.rst");
    applyStimulus("late.c1", 4'b0100, 4'b1010);
    applyStimulus("late.c2", 4'b0100, 4'b0101);
    applyStimulus("late.c3", 4'b1010, 4'b1111);
    checkVal("late.gnt", gnt, 4'b1000);

    // Two steady requesters, then a lone one
    doReset("burst.rst");
    for (int i = 0; i < 12; i++) begin
      applyStimulus("burst2", 4'b0011, 4'($urandom));
      exp_g = (BURST_ON && ((i / 4) % 2 == 1)) ? 4'b0010 : 4'b0001;
      checkVal($sformatf("burst2.gnt%0d", i), gnt, exp_g);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus("burst1", 4'b0001, 4'($urandom));
      checkVal($sformatf("burst1.gnt%0d", i), gnt, 4'b0001);
    end

    // Reset while source 1 owns the mux, then ptr restarts at 0
    doReset("mid.rst0");
    applyStimulus("mid.c1", 4'b0010, 4'b0010);
    applyStimulus("mid.c2", 4'b0010, 4'b0010);
    checkVal("mid.pre", gnt, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("mid.gnt0", gnt, 4'b0000);
    checkVal("mid.valid0", {3'b000, dout_valid}, 4'b0000);
    doReset("mid.rst1");
    applyStimulus("mid.c3", 4'b1010, 4'b0000);
    checkVal("mid.first", gnt, 4'b0010);

    // Randomized traffic with sticky requests and occasional resets
    doReset("rand.rst");
    r = 4'($urandom);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      if ($urandom_range(0, 7) == 0 && m_owner >= 0) r[m_owner] = 1'b0;
      if ($urandom_range(0, 79) == 0) doReset("rand.rst");
      applyStimulus($sformatf("rand%0d", i), r, 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, error_count);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one 4:1 single-bit mux datapath among four requesters. It drives the mux select and a one-hot grant, and registers the selected data bit with a valid flag. It sits between four independent bit-serial sources and a single downstream consumer. It is the sequencing layer that the bare 4:1 mux lacks.

## Interface
- MAX_BURST, 4: maximum consecutive grant cycles per owner (used only when the burst limit is compiled in); legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request per source; held high while the source wants the mux.
- din  input  4  data bit per source; din[k] belongs to source k.
- gnt  output  4  one-hot grant, registered; all-zero when idle.
- sel  output  2  mux select, registered; equals the encoded gnt while granted, holds its last value when idle.
- dout  output  1  registered mux output, din[sel] sampled while granted.
- dout_valid  output  1  high when dout carries a granted sample.

## Operation
- States: IDLE, GRANT. Internal state: 2-bit round-robin pointer ptr (next candidate), owner w (= sel), burst counter cnt.
- Arbitration function: first k with req[k]=1, scanning ptr, ptr+1, ... mod 4.
- IDLE:
  - If any req is high, register gnt/sel to the winner and go to GRANT.
  - ptr <= winner+1 mod 4; cnt <= 0.
  - Otherwise stay in IDLE.
- GRANT, req[w]=1 and no burst expiry: hold gnt/sel and increment cnt.
- GRANT, release (req[w]=0 or burst expiry):
  - Re-arbitrate in the same cycle with the scan starting at w+1, excluding w when it released.
  - A winner gets the grant next cycle with no gap; ptr <= winner+1; cnt <= 0.
  - With no winner, go to IDLE with gnt=0.
- Burst expiry where w is the only requester: w is re-granted and cnt resets, so gnt stays continuously high.
- Datapath: every clock, dout <= din[sel] and dout_valid <= |gnt. dout keeps its last value when dout_valid=0.
- Reset values: state IDLE, gnt 4'b0000, sel 2'b00, ptr 2'b00, cnt 0, dout 0, dout_valid 0.
- Reset mid-GRANT clears gnt and dout_valid asynchronously. After release the first arbitration favours source 0.
- Gnt is always one-hot or zero. Glitch-free sel is required: sel changes only on a clock edge.

## Timing
- Request-to-grant: a req rising at edge N, arbiter idle → gnt high after edge N+1.
- Grant-to-data: the din of the owner at edge M appears on dout/dout_valid after edge M+1, a fixed one-cycle latency.
- Release-to-handoff: the owner drops req before edge N → the new gnt is valid after edge N. There are no dead cycles when others are waiting.
- Simultaneous events: a req rising in the same cycle the owner releases takes part in that arbitration.
- Owner fairness: an owner dropping and re-raising req in consecutive cycles loses to any other pending requester.
- Worst-case wait, burst limit compiled in: 3*MAX_BURST cycles plus 1.

## Configuration
- ARB_BURST_LIMIT_EN defined: cnt (width $clog2(MAX_BURST)) is built. Expiry occurs when cnt==MAX_BURST-1 at a clock edge while req[w] is still high, and it forces re-arbitration as above.
- Undefined: no counter is built and MAX_BURST is ignored. The owner keeps the grant until it drops req, so starvation is possible by design.

## Structure
- Shared package mux_arb_pkg:
  - State enum arb_state_t {ARB_IDLE, ARB_GRANT}.
  - Constant NUM_REQ=4 and SEL_W=2.
  - A function rr_pick(req, start) that returns the found flag and a 2-bit index.
- One sub-module: mux4_sel, the combinational 4:1 bit mux (sel, din → bit), instantiated once to feed the dout register.

## Test plan
- Reset then single requester:
  - Stimulus: rst_n low with req=4'b0100, then release reset; hold req=4'b0100, din=4'b0100.
  - Response: gnt=4'b0100 and sel=2 one cycle after release; dout=1, dout_valid=1 one cycle later.
- Round-robin rotation:
  - Stimulus: req=4'b1111, each owner drops its req for one cycle after 2 grant cycles, then re-raises it.
  - Response: grant order 0,1,2,3,0 with no idle cycles between owners.
- Handoff with a late arrival:
  - Stimulus: owner 2 releases in the same cycle req[1] and req[3] rise.
  - Response: the next gnt is 4'b1000, because the scan starts at 3.
- Burst limit (ARB_BURST_LIMIT_EN, MAX_BURST=4):
  - Stimulus: req=4'b0011 held high.
  - Response: gnt alternates 4'b0001 and 4'b0010 every 4 cycles.
  - Also check req=4'b0001 alone: gnt stays high continuously.
- Reset mid-grant:
  - Stimulus: assert rst_n low between clock edges while gnt=4'b0010.
  - Response: gnt=0 and dout_valid=0 immediately without waiting for a clock edge; after release with req=4'b1010, the first grant is 4'b0010 (ptr=0 scan).
